hex_uart_tx: RTL

//  Output-side counterpart to the pushbutton bit-serial entry path: takes a parallel ALU

---
 rtl/hex_uart_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hex_uart_tx.sv
// hex_uart_tx: sends a parallel word as uppercase ASCII hex (MSB nibble first),
// optionally followed by CR LF, as back-to-back 8N1 frames on one serial line.
// Ports:
//   clk    - clock, all state on posedge
//   rstn   - asynchronous active-low reset
//   start  - send request, sampled only while busy=0
//   data   - word to send, captured on the accepting edge
//   tx     - serial line, idle high, driven from a flop
//   busy   - high while a message is in flight
//   done   - one-cycle pulse when the last stop bit completes
module hex_uart_tx #(
   parameter int CLK_DIV  = 4,
   parameter int NIBBLES  = 4,
   parameter int SEND_EOL = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] data,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);
   localparam int DW     = 4*NIBBLES;
   localparam int NBYTES = NIBBLES + 2*SEND_EOL;
   localparam int BW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW     = (NBYTES > 1)  ? $clog2(NBYTES)  : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [DW-1:0]   word_q, word_d;
   logic [7:0]      byte_q, byte_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            baud_wrap;

   // Byte i of the message: hex digits MSB nibble first, then CR, LF.
   function automatic logic [7:0] byte_for(input logic [DW-1:0] w, input logic [IW-1:0] i);
      int          ii;
      logic [DW-1:0] sh;
      logic [3:0]  n;
      ii = int'(i);
      if (ii < NIBBLES) begin
         sh = w >> (4*(NIBBLES-1-ii));
         n  = sh[3:0];
         byte_for = (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
      end else if (ii == NIBBLES) begin
         byte_for = 8'h0D;
      end else begin
         byte_for = 8'h0A;
      end
   endfunction

   assign baud_wrap = (baud_q == BW'(CLK_DIV-1));

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      word_d  = word_q;
      byte_d  = byte_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               word_d  = data;
               idx_d   = '0;
               byte_d  = byte_for(data, '0);
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (baud_wrap) begin
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = byte_q[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_wrap) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = byte_q[bit_q + 3'd1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_wrap) begin
               baud_d = '0;
               if (idx_q == IW'(NBYTES-1)) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  // next frame starts immediately, no idle gap
                  idx_d   = idx_q + 1'b1;
                  byte_d  = byte_for(word_q, idx_q + 1'b1);
                  tx_d    = 1'b0;
                  state_d = START;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         byte_q  <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         byte_q  <= byte_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule
